// File: rtl/lpddr5_dram_responder_if.sv
// rtl/lpddr5_dram_responder_if.sv - command/data bus between a DRAM controller and the responder model
//
// Purpose: bundles the command, address, write-burst and read-burst signals of
//          the LPDDR5 responder so controller and responder share one port.
// Signals:
//   dram_cmd     3                        command (0 NOP,1 ACT,2 RD,3 WR,4 PRE,5 REF)
//   dram_addr    ROW+log2(BANKS)+COL      {row, bank, col}, col in LSBs
//   dram_wdata   DATA_BITS*BURST_LENGTH   write burst
//   dram_rdata   DATA_BITS*BURST_LENGTH   registered read burst
//   dram_ready   1                        idle and accepting a command
//   rdata_valid  1                        one-cycle pulse when dram_rdata updates
//   cmd_err      1                        sticky protocol-violation flag
// Modports: master (controller side), slave (responder side).
interface lpddr5_dram_responder_if #(
  parameter int BANKS        = 16,
  parameter int ROW_BITS     = 14,
  parameter int COL_BITS     = 6,
  parameter int DATA_BITS    = 32,
  parameter int BURST_LENGTH = 16
);
  localparam int ADDR_BITS  = ROW_BITS + $clog2(BANKS) + COL_BITS;
  localparam int BURST_BITS = DATA_BITS * BURST_LENGTH;

  logic [2:0]            dram_cmd;
  logic [ADDR_BITS-1:0]  dram_addr;
  logic [BURST_BITS-1:0] dram_wdata;
  logic [BURST_BITS-1:0] dram_rdata;
  logic                  dram_ready;
  logic                  rdata_valid;
  logic                  cmd_err;

  modport master (
    output dram_cmd, dram_addr, dram_wdata,
    input  dram_rdata, dram_ready, rdata_valid, cmd_err
  );

  modport slave (
    input  dram_cmd, dram_addr, dram_wdata,
    output dram_rdata, dram_ready, rdata_valid, cmd_err
  );
endinterface

// File: rtl/lpddr5_dram_responder.sv
// rtl/lpddr5_dram_responder.sv - cycle-counting LPDDR5 DRAM responder with bank tracking and burst storage
//
// Purpose: accepts ACT/RD/WR/PRE/REF commands while idle, stays busy for the
//          command's timing parameter, tracks open banks/rows, flags protocol
//          violations and serves whole bursts from a small storage array.
// Ports:
//   clk    in   sole clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of lpddr5_dram_responder_if (command, data, status)
module lpddr5_dram_responder #(
  parameter int BANKS        = 16,
  parameter int ROW_BITS     = 14,
  parameter int COL_BITS     = 6,
  parameter int DATA_BITS    = 32,
  parameter int BURST_LENGTH = 16,
  parameter int MEM_WORDS    = 64,
  parameter int T_RCD        = 4,
  parameter int T_RP         = 4,
  parameter int T_RFC        = 16,
  parameter int T_RL         = 6,
  parameter int T_WL         = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  lpddr5_dram_responder_if.slave   bus
);
  localparam int BANK_BITS  = $clog2(BANKS);
  localparam int ADDR_BITS  = ROW_BITS + BANK_BITS + COL_BITS;
  localparam int BURST_BITS = DATA_BITS * BURST_LENGTH;
  localparam int IDX_BITS   = $clog2(MEM_WORDS);

  localparam logic [2:0] CMD_ACT = 3'd1;
  localparam logic [2:0] CMD_RD  = 3'd2;
  localparam logic [2:0] CMD_WR  = 3'd3;
  localparam logic [2:0] CMD_PRE = 3'd4;
  localparam logic [2:0] CMD_REF = 3'd5;

  typedef enum logic [2:0] {
    IDLE, BUSY_ACT, BUSY_PRE, BUSY_RD, BUSY_WR, BUSY_REF
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  illegal_q, illegal_d;
  logic [ADDR_BITS-1:0]  addr_q, addr_d;
  logic [BURST_BITS-1:0] wdata_q, wdata_d;
  logic [BANKS-1:0]      open_q, open_d;
  logic [ROW_BITS-1:0]   open_row_q [BANKS];
  logic [ROW_BITS-1:0]   open_row_d [BANKS];
  logic [BURST_BITS-1:0] rdata_q, rdata_d;
  logic                  rvalid_q, rvalid_d;
  logic                  err_q, err_d;
  logic                  mem_we;

  // Storage is deliberately not reset: contents survive rst_n.
  logic [BURST_BITS-1:0] mem [MEM_WORDS];

  logic [ROW_BITS-1:0]  in_row, cap_row;
  logic [BANK_BITS-1:0] in_bank, cap_bank;
  logic [IDX_BITS-1:0]  cap_idx;
  logic                 legal;

  assign in_row   = bus.dram_addr[ADDR_BITS-1 -: ROW_BITS];
  assign in_bank  = bus.dram_addr[COL_BITS +: BANK_BITS];
  assign cap_row  = addr_q[ADDR_BITS-1 -: ROW_BITS];
  assign cap_bank = addr_q[COL_BITS +: BANK_BITS];
  // {bank, col} sits in the address LSBs, so its low bits are the address LSBs.
  assign cap_idx  = addr_q[IDX_BITS-1:0];

  // Legality is judged against bank state at acceptance; bank state cannot
  // change while busy, so the verdict stays valid until completion.
  always_comb begin
    legal = 1'b0;
    case (bus.dram_cmd)
      CMD_ACT: legal = !open_q[in_bank];
      CMD_PRE: legal = 1'b1;
      CMD_RD,
      CMD_WR:  legal = open_q[in_bank] && (open_row_q[in_bank] == in_row);
      CMD_REF: legal = (open_q == '0);
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    illegal_d  = illegal_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    open_d     = open_q;
    open_row_d = open_row_q;
    rdata_d    = rdata_q;
    rvalid_d   = 1'b0;
    err_d      = err_q;
    mem_we     = 1'b0;

    if (state_q == IDLE) begin
      if (bus.dram_cmd >= CMD_ACT && bus.dram_cmd <= CMD_REF) begin
        addr_d    = bus.dram_addr;
        wdata_d   = bus.dram_wdata;
        illegal_d = !legal;
        case (bus.dram_cmd)
          CMD_ACT: begin state_d = BUSY_ACT; cnt_d = 8'(T_RCD); end
          CMD_RD:  begin state_d = BUSY_RD;  cnt_d = 8'(T_RL);  end
          CMD_WR:  begin state_d = BUSY_WR;  cnt_d = 8'(T_WL);  end
          CMD_PRE: begin state_d = BUSY_PRE; cnt_d = 8'(T_RP);  end
          default: begin state_d = BUSY_REF; cnt_d = 8'(T_RFC); end
        endcase
        // A rejected command still occupies the matching busy state, but for a
        // single cycle and with all side effects suppressed at completion.
        if (!legal) begin
          cnt_d = 8'd1;
          err_d = 1'b1;
        end
      end
    end else begin
      if (cnt_q <= 8'd1) begin
        state_d = IDLE;
        cnt_d   = 8'd0;
        if (!illegal_q) begin
          case (state_q)
            BUSY_ACT: begin
              open_d[cap_bank]     = 1'b1;
              open_row_d[cap_bank] = cap_row;
            end
            BUSY_PRE: open_d[cap_bank] = 1'b0;
            BUSY_RD: begin
              rdata_d  = mem[cap_idx];
              rvalid_d = 1'b1;
            end
            BUSY_WR: mem_we = 1'b1;
            default: ;
          endcase
        end
      end else begin
        cnt_d = cnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      illegal_q <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      open_q    <= '0;
      for (int b = 0; b < BANKS; b++) open_row_q[b] <= '0;
      rdata_q   <= '0;
      rvalid_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      open_q     <= open_d;
      open_row_q <= open_row_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      err_q      <= err_d;
    end
  end

  // mem_we derives from state_q, which reset forces to IDLE, so a reset
  // during BUSY_WR abandons the write.
  always_ff @(posedge clk) begin
    if (mem_we) mem[cap_idx] <= wdata_q;
  end

  assign bus.dram_ready  = (state_q == IDLE);
  assign bus.dram_rdata  = rdata_q;
  assign bus.rdata_valid = rvalid_q;
  assign bus.cmd_err     = err_q;
endmodule
